// File: rtl/snow_pkg.sv
// Shared types, constants and helpers for the SNOW 2.0 keystream sequencer.
package snow_pkg;

  localparam int WORD_W          = 32;
  localparam int LFSR_DEPTH      = 16;
  localparam int INIT_ROUNDS_DEF = 32;
  localparam int CNT_W           = 5;
  localparam int KEY_W           = 128;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LFSR_DEPTH-1:0][WORD_W-1:0] lfsr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_WARM = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Multiply v by beta^n in GF(2^8) with the SNOW field polynomial (0xA9 reduction).
  function automatic logic [7:0] mul_x_pow(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < 255; i++) begin
      if (i < n) begin
        r = r[7] ? ({r[6:0], 1'b0} ^ 8'hA9) : {r[6:0], 1'b0};
      end
    end
    return r;
  endfunction

  // LFSR contents after the accepting edge: key words, their complements, IV mixed in.
  function automatic lfsr_t load_pattern(input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] iv);
    word_t k3, k2, k1, k0;
    lfsr_t s;
    k3 = key[127:96];
    k2 = key[95:64];
    k1 = key[63:32];
    k0 = key[31:0];
    s[15] = k3 ^ iv[31:0];
    s[14] = k2;
    s[13] = k1;
    s[12] = k0 ^ iv[63:32];
    s[11] = ~k3;
    s[10] = ~k2 ^ iv[95:64];
    s[9]  = ~k1 ^ iv[127:96];
    s[8]  = ~k0;
    s[7]  = k3;
    s[6]  = k2;
    s[5]  = k1;
    s[4]  = k0;
    s[3]  = ~k3;
    s[2]  = ~k2;
    s[1]  = ~k1;
    s[0]  = ~k0;
    return s;
  endfunction

endpackage

// File: rtl/alpha.sv
// Multiplication of an LFSR word by alpha (applied to s0 in the feedback).
module alpha
  import snow_pkg::*;
(
  input  logic [WORD_W-1:0] a_in,
  output logic [WORD_W-1:0] alpha_out
);

  logic [7:0] top_s;

  assign top_s = a_in[31:24];

  // Shift the word up one byte and fold the outgoing byte back in via the MULa constants.
  always_comb begin
    alpha_out = {a_in[23:0], 8'h00} ^
                {mul_x_pow(top_s, 23), mul_x_pow(top_s, 245),
                 mul_x_pow(top_s, 48), mul_x_pow(top_s, 239)};
  end

endmodule

// File: rtl/alpha_inv.sv
// Multiplication of an LFSR word by alpha^-1 (applied to s11 in the feedback).
module alpha_inv
  import snow_pkg::*;
(
  input  logic [WORD_W-1:0] a_in,
  output logic [WORD_W-1:0] alpha_inv_out
);

  logic [7:0] low_s;

  assign low_s = a_in[7:0];

  // Shift the word down one byte and fold the outgoing byte back in via the DIVa constants.
  always_comb begin
    alpha_inv_out = {8'h00, a_in[31:8]} ^
                    {mul_x_pow(low_s, 16), mul_x_pow(low_s, 39),
                     mul_x_pow(low_s, 6), mul_x_pow(low_s, 64)};
  end

endmodule

// File: rtl/snow_fsm.sv
// SNOW 2.0 finite state machine: R1/R2 registers, the 32-bit S-box and the F output.
module snow_fsm
  import snow_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] s15,
  input  logic [WORD_W-1:0] s5,
  output logic [WORD_W-1:0] f_out
);

  logic [WORD_W-1:0] r1_r;
  logic [WORD_W-1:0] r2_r;
  logic [WORD_W-1:0] s_box_s;

  // Multiplication in the AES field (0x11B reduction).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // AES byte S-box: field inverse (a^254, with 0 -> 0) followed by the affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise S-box then MixColumn; byte 0 is the least significant byte of the word.
  function automatic logic [31:0] snow_s(input logic [31:0] w);
    logic [3:0][7:0] a;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = aes_sbox(w[8*i +: 8]);
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = gf_mul(a[i], 8'h02) ^ gf_mul(a[(i+1)%4], 8'h03) ^
                    a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

  // S-box of the current R1, the next R2 value.
  always_comb begin
    s_box_s = snow_s(r1_r);
  end

  assign f_out = (s15 + r1_r) ^ r2_r;

  // R1/R2 update together with every LFSR clock; clr zeroises and wins over en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_r <= 32'h0;
      r2_r <= 32'h0;
    end else if (clr) begin
      r1_r <= 32'h0;
      r2_r <= 32'h0;
    end else if (en) begin
      r1_r <= r2_r + s5;
      r2_r <= s_box_s;
    end
  end

endmodule

// File: rtl/snow_keystream_ctrl.sv
// SNOW 2.0 keystream sequencer: key/IV load, initialisation, warm-up and handshaked output.
module snow_keystream_ctrl
  import snow_pkg::*;
#(
  parameter int INIT_ROUNDS = INIT_ROUNDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [KEY_W-1:0]  key,
  input  logic [KEY_W-1:0]  iv,
  output logic [WORD_W-1:0] ks_data,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              busy,
  output logic              init_done
);

  state_t           state_r;
  state_t           state_n_s;
  lfsr_t            lfsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             init_done_r;
  logic             accept_s;
  logic             clock_s;
  logic             init_mode_s;
  logic             last_round_s;
  logic             fsm_clr_s;
  word_t            alpha_s;
  word_t            alpha_inv_s;
  word_t            f_s;
  word_t            fb_s;

  alpha u_alpha (
    .a_in      (lfsr_r[0]),
    .alpha_out (alpha_s)
  );

  alpha_inv u_alpha_inv (
    .a_in          (lfsr_r[11]),
    .alpha_inv_out (alpha_inv_s)
  );

  snow_fsm u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fsm_clr_s),
    .en    (clock_s),
    .s15   (lfsr_r[15]),
    .s5    (lfsr_r[5]),
    .f_out (f_s)
  );

  // Next state, LFSR clock enable/mode and feedback word; stop overrides everything.
  always_comb begin
    state_n_s    = state_r;
    accept_s     = 1'b0;
    clock_s      = 1'b0;
    init_mode_s  = 1'b0;
    last_round_s = (cnt_r == CNT_W'(INIT_ROUNDS - 1));
    if (stop) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            accept_s  = 1'b1;
            state_n_s = ST_INIT;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_INIT: begin
          clock_s     = 1'b1;
          init_mode_s = 1'b1;
          if (last_round_s) state_n_s = ST_WARM;
          else              state_n_s = ST_INIT;
        end
        ST_WARM: begin
          clock_s   = 1'b1;
          state_n_s = ST_RUN;
        end
        ST_RUN: begin
          if (ks_ready) clock_s = 1'b1;
          else          clock_s = 1'b0;
          state_n_s = ST_RUN;
        end
        default: state_n_s = ST_IDLE;
      endcase
    end
    fb_s = alpha_s ^ lfsr_r[2] ^ alpha_inv_s ^ (init_mode_s ? f_s : 32'h0);
  end

  assign fsm_clr_s = stop | accept_s;

  // Control state and the one-cycle init_done pulse marking entry to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      init_done_r <= (state_r == ST_WARM) && (state_n_s == ST_RUN);
    end
  end

  // LFSR register file and init round counter: zeroise, load, or shift in the feedback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= '0;
      cnt_r  <= 5'd0;
    end else if (stop) begin
      lfsr_r <= '0;
      cnt_r  <= 5'd0;
    end else if (accept_s) begin
      lfsr_r <= load_pattern(key, iv);
      cnt_r  <= 5'd0;
    end else if (clock_s) begin
      lfsr_r <= {fb_s, lfsr_r[LFSR_DEPTH-1:1]};
      cnt_r  <= (init_mode_s && !last_round_s) ? cnt_r + 5'd1 : 5'd0;
    end
  end

  assign ks_valid  = (state_r == ST_RUN);
  assign busy      = (state_r != ST_IDLE);
  assign ks_data   = ks_valid ? (f_s ^ lfsr_r[0]) : 32'h0;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_snow_keystream_ctrl.sv
// Bench for snow_keystream_ctrl: table-based SNOW 2.0 reference model, per-cycle compare.
module tb_snow_keystream_ctrl;

  localparam int ROUNDS = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         ks_ready = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic [31:0]  ks_data;
  logic         ks_valid;
  logic         busy;
  logic         init_done;

  int checks = 0;
  int failures = 0;

  snow_keystream_ctrl #(.INIT_ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .key       (key),
    .iv        (iv),
    .ks_data   (ks_data),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mula [256];
  logic [31:0] diva [256];
  logic [7:0]  sbox [256];
  logic [31:0] m_s  [16];
  logic [31:0] m_r1 = 32'h0;
  logic [31:0] m_r2 = 32'h0;
  int          m_phase = -1;   // -1 idle, 0..ROUNDS-1 init, ROUNDS warm, >ROUNDS run
  bit          m_pulse = 1'b0;
  logic [31:0] got_q [$];
  int          valid_seen = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xpow(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    repeat (n) r = r[7] ? ((r << 1) ^ 8'hA9) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // 32-bit S via a T-table: T0 = (3s, s, s, 2s), rotated per input byte position.
  function automatic logic [31:0] sfun(input logic [31:0] w);
    logic [31:0] acc, t;
    logic [7:0] s, s2;
    acc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      s  = sbox[w[8*i +: 8]];
      s2 = s[7] ? ((s << 1) ^ 8'h1B) : (s << 1);
      t  = {s2 ^ s, s, s, s2};
      acc = acc ^ ((t << (8*i)) | (t >> (32 - 8*i)));
    end
    return acc;
  endfunction

  function automatic logic [31:0] m_f();
    return (m_s[15] + m_r1) ^ m_r2;
  endfunction

  task automatic m_zero();
    for (int i = 0; i < 16; i++) m_s[i] = 32'h0;
    m_r1 = 32'h0;
    m_r2 = 32'h0;
  endtask

  task automatic m_load(input logic [127:0] k, input logic [127:0] v);
    logic [31:0] kw [4];
    logic [31:0] vw [4];
    for (int i = 0; i < 4; i++) begin
      kw[i] = k[32*i +: 32];
      vw[i] = v[32*i +: 32];
    end
    m_s[15] = kw[3] ^ vw[0];
    m_s[14] = kw[2];
    m_s[13] = kw[1];
    m_s[12] = kw[0] ^ vw[1];
    m_s[11] = ~kw[3];
    m_s[10] = ~kw[2] ^ vw[2];
    m_s[9]  = ~kw[1] ^ vw[3];
    m_s[8]  = ~kw[0];
    for (int i = 0; i < 4; i++) begin
      m_s[7-i] = kw[3-i];
      m_s[3-i] = ~kw[3-i];
    end
    m_r1 = 32'h0;
    m_r2 = 32'h0;
  endtask

  task automatic m_clock(input bit init);
    logic [31:0] f, fb, nr1, nr2;
    f   = m_f();
    fb  = ({m_s[0][23:0], 8'h00} ^ mula[m_s[0][31:24]]) ^ m_s[2] ^
          ({8'h00, m_s[11][31:8]} ^ diva[m_s[11][7:0]]) ^ (init ? f : 32'h0);
    nr1 = m_r2 + m_s[5];
    nr2 = sfun(m_r1);
    for (int i = 0; i < 15; i++) m_s[i] = m_s[i+1];
    m_s[15] = fb;
    m_r1 = nr1;
    m_r2 = nr2;
  endtask

  // Build alpha tables and the AES S-box (generator-walk construction).
  initial begin : build_tables
    logic [7:0] p, q;
    m_zero();
    for (int c = 0; c < 256; c++) begin
      mula[c] = {xpow(8'(c), 23), xpow(8'(c), 245), xpow(8'(c), 48), xpow(8'(c), 239)};
      diva[c] = {xpow(8'(c), 16), xpow(8'(c), 39), xpow(8'(c), 6), xpow(8'(c), 64)};
    end
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  end

  // Reference model advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      m_zero();
      m_phase = -1;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (stop) begin
        m_zero();
        m_phase = -1;
      end else if (m_phase < 0) begin
        if (start) begin
          m_load(key, iv);
          m_phase = 0;
        end
      end else if (m_phase < ROUNDS) begin
        m_clock(1'b1);
        m_phase++;
      end else if (m_phase == ROUNDS) begin
        m_clock(1'b0);
        m_phase++;
        m_pulse = 1'b1;
      end else if (ks_ready) begin
        m_clock(1'b0);
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus stall stability.
  always @(negedge clk) begin : compare
    bit          ev;
    logic [31:0] ed;
    ev = (m_phase > ROUNDS);
    ed = ev ? (m_f() ^ m_s[0]) : 32'h0;
    chk("ks_valid", 32'(ks_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(m_phase >= 0));
    chk("init_done", 32'(init_done), 32'(m_pulse));
    chk("ks_data", ks_data, ed);
    if (prev_hold && ks_valid) chk("stall_stable", ks_data, prev_data);
    prev_hold = ks_valid && !ks_ready;
    prev_data = ks_data;
    if (ks_valid) valid_seen++;
    if (ks_valid && ks_ready) got_q.push_back(ks_data);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_words(input int n, input bit rnd, input string tag);
    int budget;
    budget = 0;
    while (got_q.size() < n && budget < 2000) begin
      if (rnd) ks_ready = 1'($urandom_range(0, 1));
      tick(1);
      budget++;
    end
    chk({"words_", tag}, 32'(got_q.size() >= n), 32'd1);
  endtask

  initial begin : stim
    logic [31:0] ref_w [16];
    int lat;
    #1;
    chk("pin_sbox_01", 32'(sbox[1]), 32'h7C);
    chk("pin_sbox_53", 32'(sbox[8'h53]), 32'hED);
    chk("pin_s_zero", sfun(32'h0), 32'h63636363);
    chk("pin_mula_1", mula[1], 32'hE19FCF13);
    chk("pin_diva_1", diva[1], 32'h180F40CD);

    tick(3);
    chk("rst_valid", 32'(ks_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", ks_data, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Key 0, IV 0, ready held high: latency and reference sequence
    key = '0;
    iv = '0;
    ks_ready = 1'b1;
    got_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    lat = 1;
    while (!ks_valid && lat < 100) begin
      tick(1);
      lat++;
    end
    chk("latency", 32'(lat), 32'd34);
    chk("init_done_first", 32'(init_done), 32'd1);
    tick(1);
    chk("init_done_end", 32'(init_done), 32'd0);
    wait_words(16, 1'b0, "ref");
    for (int i = 0; i < 16; i++) ref_w[i] = got_q[i];
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);

    // Same key under random back-pressure with ignored start pulses in INIT and RUN
    got_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_words(4, 1'b1, "bp_a");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_words(16, 1'b1, "bp_b");
    for (int i = 0; i < 16; i++) chk($sformatf("seq_%0d", i), got_q[i], ref_w[i]);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;

    // Stop during INIT, then restart with the single-bit key
    key = {32'h80000000, 96'h0};
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("init_stop_busy", 32'(busy), 32'd0);
    chk("init_stop_valid", 32'(ks_valid), 32'd0);
    got_q.delete();
    ks_ready = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_words(16, 1'b0, "k80");
    chk("golden_z1", got_q[0], 32'h8D590AE9);
    chk("golden_z2", got_q[1], 32'hA74A7D05);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    valid_seen = 0;
    tick(40);
    chk("ss_no_valid", 32'(valid_seen), 32'd0);

    // Random key/IV under random ready, then asynchronous reset mid-RUN
    key = {$urandom, $urandom, $urandom, $urandom};
    iv = {$urandom, $urandom, $urandom, $urandom};
    got_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_words(30, 1'b1, "rnd");
    ks_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ks_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", ks_data, 32'h0);
    chk("arst_init_done", 32'(init_done), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
